// File: rtl/instr_mem_responder.sv
// Instruction memory answering PC fetch requests over valid/ready channels,
// with a side load port, fixed wait states and bad-address flagging.
module instr_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        busy
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] rsp_instr_reg;
    logic        rsp_err_reg;
    logic        accept;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req_bad, ld_ok;
    logic [AW-1:0] req_idx, ld_idx;

    // Anything above the addressable window or not word aligned is a bad access.
    assign req_idx = req_addr[AW+1:2];
    assign ld_idx  = ld_addr[AW+1:2];
    assign req_bad = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
    assign ld_ok   = ld_we && (ld_addr[1:0] == 2'b00) && !(|ld_addr[31:AW+2]);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        case (state_reg)
            S_IDLE: req_ready = 1'b1;
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        accept = req_valid && req_ready;
        // A new acceptance overrides the drain-to-idle path out of RESP.
        if (accept) begin
            state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            cnt_next   = WAIT_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 4'd0;
            rsp_instr_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                rsp_err_reg   <= req_bad;
                rsp_instr_reg <= req_bad ? NOP_INSTR : mem[req_idx];
            end
        end
    end

    // Write port; the read above samples the pre-write word on a same-edge hit.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

    assign rsp_valid = (state_reg == S_RESP);
    assign busy      = (state_reg != S_IDLE);
    assign rsp_instr = rsp_instr_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (0 and 3 wait states) checked
// against a queue-based fetch model, with directed scenarios then random traffic.
module tb_instr_mem_responder;

    localparam int DEPTH = 1024;
    localparam int NI    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [31:0] req_addr  [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_instr [NI];
    logic        rsp_err   [NI];
    logic        ld_we     [NI];
    logic [31:0] ld_addr   [NI];
    logic [31:0] ld_data   [NI];
    logic        busy      [NI];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_u
        localparam int W = (gi == 0) ? 0 : 3;

        instr_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
            .clk      (clk),
            .rst      (rst[gi]),
            .req_valid(req_valid[gi]),
            .req_ready(req_ready[gi]),
            .req_addr (req_addr[gi]),
            .rsp_valid(rsp_valid[gi]),
            .rsp_ready(rsp_ready[gi]),
            .rsp_instr(rsp_instr[gi]),
            .rsp_err  (rsp_err[gi]),
            .ld_we    (ld_we[gi]),
            .ld_addr  (ld_addr[gi]),
            .ld_data  (ld_data[gi]),
            .busy     (busy[gi])
        );

        // Reference: word array, queue of pending {err,instr}, and the cycle each
        // becomes visible (acceptance cycle + W + 1).
        logic [31:0] mmem [DEPTH];
        logic [32:0] exp_q [$];
        int          due_q [$];
        int          cyc = 0;

        always @(negedge clk) begin : mon
            logic        ev, er, bad;
            logic [31:0] ew;
            cyc <= cyc + 1;
            if (!rst[gi]) begin
                exp_q.delete();
                due_q.delete();
                check($sformatf("u%0d.rst_valid", gi), 32'(rsp_valid[gi]), 32'd0);
                check($sformatf("u%0d.rst_busy", gi), 32'(busy[gi]), 32'd0);
                check($sformatf("u%0d.rst_instr", gi), rsp_instr[gi], 32'd0);
                check($sformatf("u%0d.rst_err", gi), 32'(rsp_err[gi]), 32'd0);
            end else begin
                ev = 1'b0;
                if (exp_q.size() > 0) ev = (cyc >= due_q[0]);
                er = (exp_q.size() == 0) || (ev && rsp_ready[gi]);
                check($sformatf("u%0d.valid", gi), 32'(rsp_valid[gi]), 32'(ev));
                check($sformatf("u%0d.busy", gi), 32'(busy[gi]), 32'(exp_q.size() > 0));
                check($sformatf("u%0d.req_ready", gi), 32'(req_ready[gi]), 32'(er));
                if (ev) begin
                    check($sformatf("u%0d.instr", gi), rsp_instr[gi], exp_q[0][31:0]);
                    check($sformatf("u%0d.err", gi), 32'(rsp_err[gi]), 32'(exp_q[0][32]));
                    if (rsp_ready[gi]) begin
                        $display("u%0d rsp instr=%h err=%0d", gi, rsp_instr[gi], rsp_err[gi]);
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                    end
                end
                if (req_valid[gi] && er) begin
                    bad = (req_addr[gi][1:0] != 2'b00) || (req_addr[gi] >= 32'(4 * DEPTH));
                    ew  = bad ? 32'h0000_0013 : mmem[int'(req_addr[gi] >> 2)];
                    exp_q.push_back({bad, ew});
                    due_q.push_back(cyc + 1 + W);
                end
                if (ld_we[gi] && ld_addr[gi][1:0] == 2'b00 && ld_addr[gi] < 32'(4 * DEPTH))
                    mmem[int'(ld_addr[gi] >> 2)] <= ld_data[gi];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
        ld_we[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
        step();
        ld_we[k] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
        if (r == 1) return 32'h1000 + (32'($urandom_range(0, 100)) << 2);
        if (r == 2) return 32'hFFFF_FFFC;
        if (r == 3) return 32'h0000_0FFC;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b1;
            ld_we[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = '0;
        end
        #2;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b1;
        step();

        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 64; w++) load(k, 32'(w * 4), $urandom);
            load(k, 32'h0FFC, $urandom);
        end

        // Load and back-to-back fetch, zero wait states.
        load(0, 32'h0, 32'h0050_0093);
        load(0, 32'h4, 32'h00A0_0113);
        rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        step();
        check("lf_ready", 32'(req_ready[0]), 32'd1);
        check("lf_instr0", rsp_instr[0], 32'h0050_0093);
        req_addr[0] = 32'h4;
        step();
        req_valid[0] = 1'b0;
        check("lf_instr1", rsp_instr[0], 32'h00A0_0113);
        check("lf_err", 32'(rsp_err[0]), 32'd0);
        step();

        // Backpressure for three cycles, then release with a request waiting.
        rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        step();
        req_addr[0] = 32'h4;
        repeat (3) begin
            step();
            check("bp_instr", rsp_instr[0], 32'h0050_0093);
            check("bp_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        check("bp_next", rsp_instr[0], 32'h00A0_0113);
        step();

        // Misaligned and out-of-range fetches, and an ignored out-of-range load.
        req_valid[0] = 1'b1; req_addr[0] = 32'h2;
        step();
        check("bad_mis_err", 32'(rsp_err[0]), 32'd1);
        check("bad_mis_nop", rsp_instr[0], 32'h0000_0013);
        req_addr[0] = 32'h1000;
        step();
        req_valid[0] = 1'b0;
        check("bad_oor_err", 32'(rsp_err[0]), 32'd1);
        check("bad_oor_nop", rsp_instr[0], 32'h0000_0013);
        load(0, 32'h1000, 32'hDEAD_BEEF);
        req_valid[0] = 1'b1; req_addr[0] = 32'h0;
        step();
        req_valid[0] = 1'b0;
        check("bad_ld_word0", rsp_instr[0], 32'h0050_0093);
        step();

        // Read-first on a same-edge load and fetch of one word.
        load(0, 32'h8, 32'h1111_1111);
        req_valid[0] = 1'b1; req_addr[0] = 32'h8;
        ld_we[0] = 1'b1; ld_addr[0] = 32'h8; ld_data[0] = 32'h2222_2222;
        step();
        ld_we[0] = 1'b0;
        check("rf_old", rsp_instr[0], 32'h1111_1111);
        step();
        req_valid[0] = 1'b0;
        check("rf_new", rsp_instr[0], 32'h2222_2222);
        step();

        // Three wait states.
        rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = 32'h0;
        step();
        req_valid[1] = 1'b0;
        check("ws_busy", 32'(busy[1]), 32'd1);
        check("ws_v0", 32'(rsp_valid[1]), 32'd0);
        step(); check("ws_v1", 32'(rsp_valid[1]), 32'd0);
        step(); check("ws_v2", 32'(rsp_valid[1]), 32'd0);
        step(); check("ws_v3", 32'(rsp_valid[1]), 32'd1);
        step();

        // Asynchronous reset while waiting.
        req_valid[1] = 1'b1; req_addr[1] = 32'h4;
        step();
        req_valid[1] = 1'b0;
        step();
        check("rs_pre_busy", 32'(busy[1]), 32'd1);
        #2 rst[1] = 1'b0;
        #1;
        check("rs_valid", 32'(rsp_valid[1]), 32'd0);
        check("rs_busy", 32'(busy[1]), 32'd0);
        check("rs_ready", 32'(req_ready[1]), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst[1] = 1'b1;
        repeat (8) begin
            step();
            check("rs_no_stale", 32'(rsp_valid[1]), 32'd0);
        end

        // Random traffic, each instance in turn.
        for (int k = 0; k < NI; k++) begin
            repeat (300) begin
                req_valid[k] = ($urandom_range(0, 99) < 60);
                req_addr[k]  = rand_addr();
                rsp_ready[k] = ($urandom_range(0, 99) < 70);
                ld_we[k]     = ($urandom_range(0, 99) < 30);
                ld_addr[k]   = rand_addr();
                ld_data[k]   = $urandom;
                step();
            end
            req_valid[k] = 1'b0; ld_we[k] = 1'b0; rsp_ready[k] = 1'b1;
            repeat (8) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
